// File: rtl/sr512_tx.sv
// sr512_tx -- 512-bit state-frame transmitter.
//
// Every cycle a frame is emitted: the selected payload is XORed with the
// KA_ANCHOR and rotated left by a data-dependent amount derived from the
// previous frame. After reset or resync, PREAMBLE_LEN idle frames are sent
// before user data flows. User data is buffered in a two-entry FIFO.
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst_n      : asynchronous active-low reset
//   s_in       : 512-bit payload to transmit
//   s_valid    : s_in valid
//   s_ready    : block accepts s_in this cycle
//   resync     : single-cycle request to re-enter preamble
//   m_out      : registered encoded frame
//   m_is_data  : m_out carries a user payload
//   m_delta    : rotation applied to the current m_out
//   frame_cnt  : number of data frames sent (wraps)
module sr512_tx #(
   parameter logic [511:0] KA_ANCHOR    = '0,
   parameter logic [511:0] IDLE_WORD    = '0,
   parameter int unsigned  PREAMBLE_LEN = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [511:0] s_in,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic         resync,
   output logic [511:0] m_out,
   output logic         m_is_data,
   output logic [8:0]   m_delta,
   output logic [31:0]  frame_cnt
);

   typedef enum logic {PREAMBLE, RUN} state_t;

   state_t       state;
   logic [7:0]   pre_cnt;
   logic [511:0] fifo_mem [2];
   logic         wr_ptr, rd_ptr;
   logic [1:0]   fifo_cnt;
   logic         rdy_q;     // low only while in reset, so s_ready stays 0 there

   logic [8:0]   d;
   logic         in_pre, last_pre, push, pop;
   logic [7:0]   eff_cnt;
   logic [511:0] payload, frame;

   function automatic logic [511:0] rol512(input logic [511:0] x, input logic [8:0] n);
      logic [1023:0] t;
      t = {x, x} << n;
      return t[1023:512];
   endfunction

   // Rotation amount: bitwise 2-of-3 majority of three slices of the last frame.
   assign d = (m_out[8:0]     & m_out[165:157]) |
              (m_out[8:0]     & m_out[319:311]) |
              (m_out[165:157] & m_out[319:311]);

   assign s_ready = rdy_q & ~fifo_cnt[1];
   assign push    = s_valid & s_ready;

   // A resync edge behaves like the first preamble frame, whatever the state.
   assign in_pre   = (state == PREAMBLE) | resync;
   assign eff_cnt  = resync ? 8'd0 : pre_cnt;
   assign last_pre = (eff_cnt == 8'(PREAMBLE_LEN - 1));
   assign pop      = ~in_pre & (fifo_cnt != 2'd0);

   assign payload = pop ? fifo_mem[rd_ptr] : IDLE_WORD;
   assign frame   = rol512(payload ^ KA_ANCHOR, d);

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= s_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PREAMBLE;
         pre_cnt   <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         fifo_cnt  <= '0;
         rdy_q     <= 1'b0;
         m_out     <= '0;
         m_delta   <= '0;
         m_is_data <= 1'b0;
         frame_cnt <= '0;
      end else begin
         rdy_q     <= 1'b1;
         m_out     <= frame;
         m_delta   <= d;
         m_is_data <= pop;
         if (pop)  frame_cnt <= frame_cnt + 32'd1;
         if (push) wr_ptr    <= ~wr_ptr;
         if (pop)  rd_ptr    <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
         if (in_pre) begin
            if (last_pre) begin
               state   <= RUN;
               pre_cnt <= '0;
            end else begin
               state   <= PREAMBLE;
               pre_cnt <= eff_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sr512_tx.sv
// tb_sr512_tx -- directed and loopback bench for sr512_tx.
// dut0 uses default parameters for hand-computed frames; dut1 uses a
// nonzero anchor/idle word and is checked through a receiver model.
module tb_sr512_tx;

   localparam logic [511:0] KA1   = {16{32'h9E3779B9}} ^ (512'h1 << 300);
   localparam logic [511:0] IDLE1 = {8{64'h0123456789ABCDEF}};
   localparam logic [511:0] W_A   = 512'h5A << 32;
   localparam logic [511:0] W_B   = 512'h3C << 400;
   localparam logic [511:0] W_C   = 512'h77 << 200;
   localparam logic [511:0] ONES  = '1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [511:0] s_in0, m_out0, s_in1, m_out1;
   logic         s_valid0, s_ready0, resync0, m_is_data0;
   logic         s_valid1, s_ready1, resync1, m_is_data1;
   logic [8:0]   m_delta0, m_delta1;
   logic [31:0]  frame_cnt0, frame_cnt1;

   sr512_tx dut0 (
      .clk(clk), .rst_n(rst_n), .s_in(s_in0), .s_valid(s_valid0), .s_ready(s_ready0),
      .resync(resync0), .m_out(m_out0), .m_is_data(m_is_data0), .m_delta(m_delta0),
      .frame_cnt(frame_cnt0)
   );

   sr512_tx #(.KA_ANCHOR(KA1), .IDLE_WORD(IDLE1), .PREAMBLE_LEN(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .s_in(s_in1), .s_valid(s_valid1), .s_ready(s_ready1),
      .resync(resync1), .m_out(m_out1), .m_is_data(m_is_data1), .m_delta(m_delta1),
      .frame_cnt(frame_cnt1)
   );

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] mv(input logic [511:0] m);
      return (m[8:0] & m[165:157]) | (m[8:0] & m[319:311]) | (m[165:157] & m[319:311]);
   endfunction

   function automatic logic [511:0] ror512(input logic [511:0] x, input logic [8:0] n);
      logic [1023:0] t;
      t = {x, x} >> n;
      return t[511:0];
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      logic [511:0] q[$];
      logic [511:0] prev_m, dec, exp_w;
      logic [8:0]   exp_d;
      int           sent, got;

      s_in0 = '0; s_valid0 = 1'b0; resync0 = 1'b0;
      s_in1 = '0; s_valid1 = 1'b0; resync1 = 1'b0;
      tick; tick;

      // reset state
      chk("rst_m_out", m_out0, '0);
      chk("rst_delta", m_delta0, '0);
      chk("rst_is_data", m_is_data0, '0);
      chk("rst_frame_cnt", frame_cnt0, '0);
      chk("rst_s_ready", s_ready0, '0);

      // hold s_valid through the preamble: only two words fit
      rst_n = 1'b1; s_valid0 = 1'b1; s_in0 = W_A;
      tick; // edge 1: no accept (s_ready was 0)
      chk("pre1_m_out", m_out0, '0);
      chk("pre1_delta", m_delta0, '0);
      chk("pre1_is_data", m_is_data0, '0);
      chk("pre1_s_ready", s_ready0, 1);
      tick; // edge 2: W_A accepted
      chk("pre2_s_ready", s_ready0, 1);
      s_in0 = W_B;
      tick; // edge 3: W_B accepted, FIFO full
      chk("pre3_s_ready_full", s_ready0, 0);
      s_in0 = W_C;
      tick; // edge 4: last preamble frame, W_C refused
      chk("pre4_is_data", m_is_data0, 0);
      chk("pre4_m_out", m_out0, '0);
      chk("pre4_frame_cnt", frame_cnt0, 0);
      s_valid0 = 1'b0;
      tick; // edge 5: W_A
      chk("run1_m_out", m_out0, W_A);
      chk("run1_is_data", m_is_data0, 1);
      chk("run1_frame_cnt", frame_cnt0, 1);
      tick; // edge 6: W_B
      chk("run2_m_out", m_out0, W_B);
      chk("run2_frame_cnt", frame_cnt0, 2);
      tick; // edge 7: empty FIFO, idle
      chk("idle_m_out", m_out0, '0);
      chk("idle_is_data", m_is_data0, 0);

      // all-ones then 1: rotation by 0 then by 511
      s_valid0 = 1'b1; s_in0 = ONES;
      tick; // edge 8: ones accepted
      chk("ones_push_is_data", m_is_data0, 0);
      s_in0 = 512'h1;
      tick; // edge 9: ones out, 1 accepted
      chk("ones_m_out", m_out0, ONES);
      chk("ones_delta", m_delta0, 9'h000);
      s_valid0 = 1'b0;
      tick; // edge 10
      chk("one_m_out", m_out0, 512'h1 << 511);
      chk("one_delta", m_delta0, 9'h1FF);
      chk("one_frame_cnt", frame_cnt0, 4);
      tick; // edge 11
      chk("after_rot_m_out", m_out0, '0);

      // resync in RUN with a word buffered, then resync again mid-preamble
      s_valid0 = 1'b1; s_in0 = W_C;
      tick; // edge 12: W_C accepted
      s_valid0 = 1'b0; resync0 = 1'b1;
      tick; // edge 13: preamble #1
      chk("rs_pre1_is_data", m_is_data0, 0);
      resync0 = 1'b0;
      tick; // edge 14: preamble #2
      chk("rs_pre2_is_data", m_is_data0, 0);
      resync0 = 1'b1;
      tick; // edge 15: restart, preamble #1
      chk("rs_restart_is_data", m_is_data0, 0);
      resync0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk($sformatf("rs_pre_tail%0d_is_data", i), m_is_data0, 0);
         chk($sformatf("rs_pre_tail%0d_m_out", i), m_out0, '0);
      end
      tick; // edge 19: buffered word
      chk("rs_word_m_out", m_out0, W_C);
      chk("rs_word_is_data", m_is_data0, 1);
      chk("rs_frame_cnt", frame_cnt0, 5);

      // loopback through a receiver model on dut1
      sent = 0; got = 0;
      prev_m = m_out1;
      for (int cyc = 0; cyc < 40000 && (sent < 10000 || q.size() != 0); cyc++) begin
         s_valid1 = (sent < 10000) && ($urandom_range(0, 9) < 7);
         s_in1    = rand512();
         resync1  = ($urandom_range(0, 299) == 0);
         if (s_valid1 && s_ready1) begin
            q.push_back(s_in1);
            sent++;
         end
         tick;
         exp_d = mv(prev_m);
         chk("lb_delta", m_delta1, exp_d);
         dec = ror512(m_out1, exp_d) ^ KA1;
         if (m_is_data1) begin
            exp_w = (q.size() > 0) ? q.pop_front() : 'x;
            chk("lb_data", dec, exp_w);
            got++;
         end else begin
            chk("lb_idle", dec, IDLE1);
         end
         prev_m = m_out1;
      end
      s_valid1 = 1'b0; resync1 = 1'b0;
      chk("lb_received", got, 10000);
      chk("lb_pending", q.size(), 0);
      chk("lb_frame_cnt", frame_cnt1, 10000);

      // asynchronous reset mid-stream with a word buffered
      s_valid1 = 1'b1; s_in1 = rand512(); resync1 = 1'b1;
      tick;
      s_valid1 = 1'b0; resync1 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_out", m_out1, '0);
      chk("arst_delta", m_delta1, '0);
      chk("arst_is_data", m_is_data1, 0);
      chk("arst_frame_cnt", frame_cnt1, 0);
      chk("arst_s_ready", s_ready1, 0);
      tick;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk($sformatf("arst_after%0d_is_data", i), m_is_data1, 0);
      end
      chk("arst_after_frame_cnt", frame_cnt1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/sr512_tx.md
SR512_TX -- requirements
Module: sr512_tx

Interface
REQ-001 The block SHALL have parameter KA_ANCHOR, default 512'h0, the 512-bit anchor XORed into every frame.
REQ-002 The block SHALL have parameter IDLE_WORD, default 512'h0, the 512-bit payload sent when no data is available.
REQ-003 The block SHALL have parameter PREAMBLE_LEN, default 4, range 1..255: idle frames forced after reset or resync.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port s_in, input, 512 bits: state payload to transmit.
REQ-007 The block SHALL have port s_valid, input, 1 bit: s_in valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit: block accepts s_in this cycle.
REQ-009 The block SHALL have port resync, input, 1 bit: single-cycle request to re-enter preamble.
REQ-010 The block SHALL have port m_out, output, 512 bits: registered encoded frame, driven every cycle.
REQ-011 The block SHALL have port m_is_data, output, 1 bit: m_out carries a user payload, not idle or preamble.
REQ-012 The block SHALL have port m_delta, output, 9 bits: rotation amount applied to the current m_out.
REQ-013 The block SHALL have port frame_cnt, output, 32 bits: count of data frames sent; wraps at 2^32.

Function
REQ-014 The block SHALL compute d = MV(m_out[8:0], m_out[165:157], m_out[319:311]) combinationally from the current m_out, where MV is the bitwise 2-of-3 majority.
REQ-015 On every clock edge out of reset, the block SHALL load m_out with ROL(P ^ KA_ANCHOR, d) and m_delta with d.
- P is the selected payload; ROL is a 512-bit left rotation.
- ROL by 0 is the identity; rotation amounts 0..511 are all legal.
REQ-016 The block SHALL use a two-entry FIFO for s_in; s_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries, decoded from registers only.
REQ-017 A word SHALL be accepted on an edge where s_valid and s_ready are both 1.
REQ-018 The FSM SHALL have two states: PREAMBLE and RUN.
REQ-019 PREAMBLE behaviour:
- P = IDLE_WORD and m_is_data = 0 for PREAMBLE_LEN consecutive frames, then the FSM goes to RUN.
- FIFO accepts input, but nothing is popped.
REQ-020 RUN behaviour:
- FIFO non-empty: pop the head, P = head, m_is_data = 1, frame_cnt increments.
- FIFO empty: P = IDLE_WORD, m_is_data = 0.
REQ-021 On a simultaneous push and pop with one entry held, the block SHALL keep the count at 1 and preserve ordering.
REQ-022 On a push into an empty FIFO in RUN, the block SHALL pop that word on the following edge, giving one-cycle latency from acceptance to m_out.
REQ-023 resync = 1 in RUN SHALL cause the next frame to be the first preamble frame.
- FIFO contents are retained and order is preserved.
- No data is dropped.
REQ-024 resync = 1 during PREAMBLE SHALL restart the preamble count, so PREAMBLE_LEN full frames follow.
REQ-025 The frames generated with d SHALL decode exactly to P by a receiver that computes ROR(m, delta) ^ KA_ANCHOR, with delta updated from the previous m.

Reset
REQ-026 While rst_n = 0, the block SHALL hold:
- m_out = 0, m_delta = 0, m_is_data = 0
- frame_cnt = 0, FIFO empty
- FSM in PREAMBLE with the preamble count at 0
- s_ready = 0
REQ-027 On the first edge after rst_n rises, the block SHALL emit its first preamble frame with d = 0, since MV of an all-zero m_out is 0, and SHALL set s_ready = 1.
REQ-028 Asserting reset mid-operation SHALL discard FIFO contents and frame_cnt immediately and asynchronously.

Verification
REQ-029 Scenario: KA_ANCHOR = 0, IDLE_WORD = 0, PREAMBLE_LEN = 4, no input.
- Required: 4 frames with m_out = 0, m_is_data = 0, m_delta = 0, then idle frames.
- Required: frame_cnt stays 0.
REQ-030 Scenario: in RUN, push all-ones, then push 512'h1 on the next cycle.
- Required: first data frame m_out = all-ones with m_delta = 0.
- Required: second frame has m_delta = 9'h1FF and m_out = 512'h1 << 511.
- Required: frame_cnt = 2.
REQ-031 Scenario: hold s_valid = 1 with distinct words during the preamble.
- Required: exactly 2 words accepted, then s_ready = 0.
- Required: both words appear in order as the first two RUN frames.
REQ-032 Scenario: pulse resync in RUN with 1 word buffered.
- Required: PREAMBLE_LEN idle frames, then the buffered word, with no loss.
REQ-033 Scenario: assert rst_n = 0 mid-stream with KA_ANCHOR = random.
- Required: all outputs match REQ-026 immediately.
REQ-034 Scenario: loop back through a receiver model, with random KA_ANCHOR and 10,000 random payloads under random s_valid.
- Required: every frame with m_is_data = 1 recovers the pushed word bit-exact and in order.
